// File: rtl/step_sequencer_if.sv
// Button inputs and strobe/status outputs exchanged between the board glue and step_sequencer.
interface step_sequencer_if;
    logic [3:0] Key;
    logic       ManualClock;
    logic       Step;
    logic       Clear;
    logic       Running;
    logic       Fast;

    modport master (output Key, ManualClock, input Step, Clear, Running, Fast);
    modport slave  (input Key, ManualClock, output Step, Clear, Running, Fast);
endinterface

// File: rtl/step_sequencer.sv
// Step/Clear strobe generator for the digit counters: prescaled tick, conditioned buttons, RUN/PAUSE FSM.
// Define STEP_SEQ_DEBOUNCE_EN to insert debouncers after the input synchronizers.
module step_sequencer #(
    parameter int TICK_DIV        = 1000000,
    parameter int FAST_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic            Clock,
    input  logic            Reset,
    step_sequencer_if.slave bus
);
    localparam int CW  = $clog2(TICK_DIV);
    localparam int MAN = 0;
    localparam int TOG = 1;
    localparam int CLR = 2;
    localparam int FST = 3;

    typedef enum logic {RUN, PAUSE} state_t;

    logic [3:0]    raw, sync1, sync2, stable;
    logic [2:0]    stable_d, press;
    state_t        state;
    logic [CW-1:0] count, term;
    logic          tick, step_q, clear_q;
    logic          unused_ok;

    assign raw = {bus.Key[2:0], bus.ManualClock};

    // NOTE: clocked blocks use only non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef STEP_SEQ_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DW-1:0] db_cnt [4];

    // NOTE: the counter array is a few flops, not a memory, so it is reset along with everything else.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign unused_ok = &{1'b0, bus.Key[3]};
`else
    assign stable    = sync2;
    assign unused_ok = &{1'b0, bus.Key[3], DEBOUNCE_CYCLES[0]};
`endif

    assign press = stable[2:0] & ~stable_d;
    assign term  = stable[FST] ? CW'(FAST_DIV - 1) : CW'(TICK_DIV - 1);
    // >= rather than == so switching to fast mode with a large count ticks at once.
    assign tick  = (state == RUN) && (count >= term);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stable_d <= '0;
            state    <= RUN;
            count    <= '0;
            step_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            stable_d <= stable[2:0];
            clear_q  <= press[CLR];
            step_q   <= !press[CLR] && (tick || press[MAN]);

            if (press[TOG]) state <= (state == RUN) ? PAUSE : RUN;

            if (press[CLR]) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= (tick || press[MAN]) ? '0 : count + 1'b1;
            end
        end
    end

    assign bus.Step    = step_q;
    assign bus.Clear   = clear_q;
    assign bus.Running = (state == RUN);
    assign bus.Fast    = stable[FST];
endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: directed scenarios then random button activity against a cycle model.
module tb_step_sequencer;
    localparam int TICK_DIV = 10;
    localparam int FAST_DIV = 4;
    localparam int DEB      = 3;
    localparam int HMAX     = 8192;

    typedef struct {
        int cyc;
        bit step;
        bit clear;
    } strobe_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    step_sequencer_if bus ();

    step_sequencer #(
        .TICK_DIV       (TICK_DIV),
        .FAST_DIV       (FAST_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    bit      started = 1'b0;
    strobe_t sb[$];

    // Reference state: raw samples since the last reset, accepted levels, run flag, run cycles since restart.
    bit hist [4][HMAX];
    int nsr = 0;
    bit m_stable [4];
    bit m_prev [3];
    bit m_running = 1'b1;
    int m_elapsed = 0;

    always @(posedge Clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit sample(input int i, input int j);
        if (j < 0) return 1'b0;
        return hist[i][j];
    endfunction

    // r = {fast, clear, toggle, manual}; predicts what the edge numbered k produces.
    task automatic model_edge(input int k, input bit rst, input bit [3:0] r);
        bit [2:0] press;
        bit       was_running, tick, step_e, clear_e, all_diff;
        int       period, c;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_stable[i] = 1'b0;
            for (int i = 0; i < 3; i++) m_prev[i] = 1'b0;
            nsr       = 0;
            m_running = 1'b1;
            m_elapsed = 0;
            return;
        end
        for (int i = 0; i < 3; i++) press[i] = m_stable[i] && !m_prev[i];
        period      = m_stable[3] ? FAST_DIV : TICK_DIV;
        was_running = m_running;
        tick        = was_running && (m_elapsed >= period - 1);
        clear_e     = press[2];
        step_e      = !clear_e && (tick || press[0]);
        if (press[1]) m_running = !m_running;
        if (clear_e) m_elapsed = 0;
        else if (was_running) m_elapsed = (tick || press[0]) ? 0 : m_elapsed + 1;
        if (step_e || clear_e) sb.push_back('{cyc: k, step: step_e, clear: clear_e});

        for (int i = 0; i < 3; i++) m_prev[i] = m_stable[i];
        c = nsr;
        if (nsr < HMAX - 1) nsr++;
        for (int i = 0; i < 4; i++) begin
            hist[i][c] = r[i];
`ifdef STEP_SEQ_DEBOUNCE_EN
            // Accepted level flips once the last DEB synchronized samples all disagree with it.
            all_diff = 1'b1;
            for (int j = c - 2; j >= c - DEB - 1; j--)
                if (sample(i, j) == m_stable[i]) all_diff = 1'b0;
            if (all_diff) m_stable[i] = !m_stable[i];
`else
            all_diff     = 1'b0;
            m_stable[i]  = sample(i, c - 1);
`endif
        end
    endtask

    task automatic drive(input bit rst, input bit [3:0] r);
        @(posedge Clock);
        #2;
        if (started) begin
            check("running", bus.Running, m_running);
            check("fast", bus.Fast, m_stable[3]);
        end
        Reset           = rst;
        bus.Key         = {1'($urandom_range(0, 1)), r[3:1]};
        bus.ManualClock = r[0];
        model_edge(cyc + 1, rst, r);
        if (rst) started = 1'b1;
    endtask

    task automatic hold(input bit [3:0] r, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, r);
    endtask

    always @(negedge Clock) begin : monitor
        strobe_t e;
        if (started) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL strobe_missing: cycle %0d required step=%0b clear=%0b, got none",
                         sb[0].cyc, sb[0].step, sb[0].clear);
                void'(sb.pop_front());
            end
            check("step_clear_exclusive", bus.Step & bus.Clear, 1'b0);
            if (bus.Step === 1'b1 || bus.Clear === 1'b1) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_unexpected at cycle %0d: got step=%0b clear=%0b, required none",
                             cyc, bus.Step, bus.Clear);
                end else begin
                    e = sb.pop_front();
                    check("step", bus.Step, e.step);
                    check("clear", bus.Clear, e.clear);
                end
            end
        end
    end

    initial begin
        int       hold_left [4];
        bit [3:0] cur;
        bus.Key         = '0;
        bus.ManualClock = 1'b0;

        for (int i = 0; i < 3; i++) drive(1'b1, 4'b0000);
        hold(4'b0000, 35);                               // free-running ticks
        hold(4'b0010, 6);  hold(4'b0000, 20);            // pause
        hold(4'b0010, 6);  hold(4'b0000, 15);            // resume
        hold(4'b0010, 6);  hold(4'b0000, 6);             // pause again
        hold(4'b0001, 6);  hold(4'b0000, 8);             // manual step while paused
        hold(4'b0001, 1);  hold(4'b0000, 1);  hold(4'b0001, 1);  hold(4'b0000, 8);  // bounce
        hold(4'b0010, 6);  hold(4'b0000, 7);             // resume
        hold(4'b0001, 6);  hold(4'b0000, 14);            // manual step while running
        hold(4'b0101, 6);  hold(4'b0000, 16);            // clear and manual together
        hold(4'b1000, 25); hold(4'b0000, 14);            // fast mode
        hold(4'b0000, 3);  hold(4'b1000, 12); hold(4'b0000, 10);
        drive(1'b1, 4'b0001); drive(1'b1, 4'b0000);      // mid-run reset
        hold(4'b0000, 15);

        for (int i = 0; i < 4; i++) hold_left[i] = 0;
        cur = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold_left[i] == 0) begin
                    if (i == 3) begin
                        cur[i]       = 1'($urandom_range(0, 1));
                        hold_left[i] = $urandom_range(5, 40);
                    end else begin
                        cur[i]       = ($urandom_range(0, 2) == 0);
                        hold_left[i] = $urandom_range(1, 9);
                    end
                end
                hold_left[i]--;
            end
            drive($urandom_range(0, 499) == 0, cur);
        end

        hold(4'b0000, 20);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
